// File: rtl/pulse_stretch_if.sv
// Request/status bundle for the pulse stretcher.
// pulse_in is a plain level request with no handshake: every rising clock
// edge that samples it high is one request; the status outputs are
// registered and change only on rising clock edges.
interface pulse_stretch_if;
    logic       pulse_in;
    logic       level_out;
    logic       busy;
    logic       pending;
    logic       dropped;
    logic [7:0] drop_cnt;
    logic [1:0] state_dbg;

    // Requester side: drives pulse_in, observes status.
    modport master (
        output pulse_in,
        input  level_out, busy, pending, dropped, drop_cnt, state_dbg
    );

    // Stretcher side.
    modport slave (
        input  pulse_in,
        output level_out, busy, pending, dropped, drop_cnt, state_dbg
    );
endinterface

// File: rtl/pulse_stretch.sv
// Pulse stretcher: each accepted request produces HOLD_CYC cycles of
// level_out high followed by at least GAP_CYC low cycles. One further
// request can be queued while busy; anything beyond that is dropped and
// counted in a saturating 8-bit counter.
module pulse_stretch #(
    parameter int HOLD_CYC = 10,
    parameter int GAP_CYC  = 10,
    parameter int CNT_W    = 16
) (
    input  logic           clk,
    input  logic           rst,
    pulse_stretch_if.slave bus
);

    localparam longint MAX_CNT = (longint'(1) << CNT_W) - 1;

    // Parameter sanity checks, evaluated at elaboration only.
    if ((HOLD_CYC < 1) || (longint'(HOLD_CYC) > MAX_CNT)) begin : g_bad_hold
        $error("pulse_stretch: HOLD_CYC=%0d outside 1..2^CNT_W-1", HOLD_CYC);
    end
    if ((GAP_CYC < 1) || (longint'(GAP_CYC) > MAX_CNT)) begin : g_bad_gap
        $error("pulse_stretch: GAP_CYC=%0d outside 1..2^CNT_W-1", GAP_CYC);
    end

    // Counters count down to zero, so the load is one less than the length.
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             level_q;
    logic             busy_q;
    logic             pending_q;
    logic             dropped_q;
    logic [7:0]       drop_cnt_q;

    // FSM, counter and all registered status outputs in one place.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            level_q    <= 1'b0;
            busy_q     <= 1'b0;
            pending_q  <= 1'b0;
            dropped_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            dropped_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.pulse_in) begin
                        state   <= HOLD;
                        cnt     <= HOLD_LOAD;
                        level_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        state   <= GAP;
                        cnt     <= GAP_LOAD;
                        level_q <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                    // Requests while busy only queue; they never extend HOLD.
                    if (bus.pulse_in) begin
                        if (!pending_q) begin
                            pending_q <= 1'b1;
                        end else begin
                            dropped_q <= 1'b1;
                            if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
                        end
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        if (pending_q || bus.pulse_in) begin
                            // The queued request is consumed; a request on this
                            // same edge refills the slot instead of dropping.
                            state     <= HOLD;
                            cnt       <= HOLD_LOAD;
                            level_q   <= 1'b1;
                            pending_q <= pending_q && bus.pulse_in;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                        if (bus.pulse_in) begin
                            if (!pending_q) begin
                                pending_q <= 1'b1;
                            end else begin
                                dropped_q <= 1'b1;
                                if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
                            end
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    level_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.level_out = level_q;
    assign bus.busy      = busy_q;
    assign bus.pending   = pending_q;
    assign bus.dropped   = dropped_q;
    assign bus.drop_cnt  = drop_cnt_q;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed bench for pulse_stretch with HOLD_CYC=3, GAP_CYC=2, CNT_W=4.
// Edge numbers in each test count rising edges after the reset edge, so
// edge 1 here corresponds to "edge 5" in the reference scenarios.
module tb_pulse_stretch;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors    = 0;
    int   miscompares = 0;

    pulse_stretch_if bus ();

    pulse_stretch #(.HOLD_CYC(3), .GAP_CYC(2), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock
    always #5 clk = ~clk;

    // Drive one edge with the given request/reset, sample 1 ns after it.
    task automatic step(input logic p, input logic r);
        bus.pulse_in = p;
        rst          = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b1);
        rst = 1'b0;
    endtask

    // Reset with a simultaneous request: request is discarded, all outputs 0.
    task automatic test_reset();
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        vectors++;
        if (bus.level_out !== 1'b0) begin miscompares++; $display("FAIL reset_level got %b expected 0", bus.level_out); end
        vectors++;
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b expected 0", bus.busy); end
        vectors++;
        if (bus.pending !== 1'b0) begin miscompares++; $display("FAIL reset_pending got %b expected 0", bus.pending); end
        vectors++;
        if (bus.dropped !== 1'b0) begin miscompares++; $display("FAIL reset_dropped got %b expected 0", bus.dropped); end
        vectors++;
        if (bus.drop_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_drop_cnt got %0d expected 0", bus.drop_cnt); end
        vectors++;
        if (bus.state_dbg !== 2'd0) begin miscompares++; $display("FAIL reset_state got %0d expected 0", bus.state_dbg); end
        rst = 1'b0;
    endtask

    // One pulse: level high edges 1-3, busy edges 1-5, idle from edge 6.
    task automatic test_single();
        logic el, eb;
        do_reset();
        for (int e = 1; e <= 8; e++) begin
            step(e == 1, 1'b0);
            el = (e <= 3);
            eb = (e <= 5);
            vectors++;
            if (bus.level_out !== el) begin miscompares++; $display("FAIL single_level edge %0d got %b expected %b", e, bus.level_out, el); end
            vectors++;
            if (bus.busy !== eb) begin miscompares++; $display("FAIL single_busy edge %0d got %b expected %b", e, bus.busy, eb); end
            vectors++;
            if (bus.pending !== 1'b0) begin miscompares++; $display("FAIL single_pending edge %0d got %b expected 0", e, bus.pending); end
        end
        vectors++;
        if (bus.state_dbg !== 2'd0) begin miscompares++; $display("FAIL single_idle got %0d expected 0", bus.state_dbg); end
    endtask

    // Two pulses: second queued, hold again at edges 6-8, never dropped.
    task automatic test_queued();
        logic el, ep;
        do_reset();
        for (int e = 1; e <= 12; e++) begin
            step((e == 1) || (e == 2), 1'b0);
            el = (e <= 3) || (e >= 6 && e <= 8);
            ep = (e >= 2 && e <= 5);
            vectors++;
            if (bus.level_out !== el) begin miscompares++; $display("FAIL queued_level edge %0d got %b expected %b", e, bus.level_out, el); end
            vectors++;
            if (bus.pending !== ep) begin miscompares++; $display("FAIL queued_pending edge %0d got %b expected %b", e, bus.pending, ep); end
            vectors++;
            if (bus.dropped !== 1'b0) begin miscompares++; $display("FAIL queued_dropped edge %0d got %b expected 0", e, bus.dropped); end
            vectors++;
            if (bus.busy !== (e <= 10)) begin miscompares++; $display("FAIL queued_busy edge %0d got %b expected %b", e, bus.busy, (e <= 10)); end
        end
    endtask

    // Three pulses: third dropped (one-cycle strobe), exactly two holds.
    task automatic test_drop();
        logic ed;
        logic prev;
        int   holds;
        holds = 0;
        prev  = 1'b0;
        do_reset();
        for (int e = 1; e <= 14; e++) begin
            step(e <= 3, 1'b0);
            ed = (e == 3);
            if (bus.level_out && !prev) holds++;
            prev = bus.level_out;
            vectors++;
            if (bus.dropped !== ed) begin miscompares++; $display("FAIL drop_strobe edge %0d got %b expected %b", e, bus.dropped, ed); end
        end
        vectors++;
        if (bus.drop_cnt !== 8'd1) begin miscompares++; $display("FAIL drop_cnt got %0d expected 1", bus.drop_cnt); end
        vectors++;
        if (holds !== 2) begin miscompares++; $display("FAIL drop_holds got %0d expected 2", holds); end
    endtask

    // Request on the last GAP cycle: HOLD restarts at edge 6, busy never drops.
    task automatic test_last_gap();
        logic el;
        do_reset();
        for (int e = 1; e <= 11; e++) begin
            step((e == 1) || (e == 5), 1'b0);
            el = (e <= 3) || (e >= 6 && e <= 8);
            vectors++;
            if (bus.level_out !== el) begin miscompares++; $display("FAIL lastgap_level edge %0d got %b expected %b", e, bus.level_out, el); end
            vectors++;
            if (bus.busy !== (e <= 10)) begin miscompares++; $display("FAIL lastgap_busy edge %0d got %b expected %b", e, bus.busy, (e <= 10)); end
        end
    endtask

    // Reset mid-HOLD, and reset mid-GAP with a queued request.
    task automatic test_rst_mid();
        do_reset();
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        vectors++;
        if ({bus.level_out, bus.busy, bus.pending, bus.dropped} !== 4'b0000) begin
            miscompares++; $display("FAIL rsthold_outs got %b expected 0000", {bus.level_out, bus.busy, bus.pending, bus.dropped});
        end
        for (int e = 1; e <= 8; e++) begin
            step(1'b0, 1'b0);
            vectors++;
            if (bus.level_out !== 1'b0) begin miscompares++; $display("FAIL rsthold_after edge %0d got %b expected 0", e, bus.level_out); end
        end
        do_reset();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        vectors++;
        if ({bus.level_out, bus.busy, bus.pending} !== 3'b000) begin
            miscompares++; $display("FAIL rstgap_outs got %b expected 000", {bus.level_out, bus.busy, bus.pending});
        end
        for (int e = 1; e <= 8; e++) begin
            step(1'b0, 1'b0);
            vectors++;
            if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rstgap_after edge %0d got %b expected 0", e, bus.busy); end
        end
    endtask

    // Continuous request for 600 edges: period 5, drops saturate at 255.
    task automatic test_back_to_back();
        logic el, ed;
        int   exp_cnt;
        exp_cnt = 0;
        do_reset();
        for (int e = 1; e <= 600; e++) begin
            step(1'b1, 1'b0);
            el = ((e - 1) % 5) < 3;
            ed = (e >= 3) && (((e - 1) % 5) != 0);
            if (ed && exp_cnt < 255) exp_cnt++;
            vectors++;
            if (bus.level_out !== el) begin miscompares++; $display("FAIL b2b_level edge %0d got %b expected %b", e, bus.level_out, el); end
            vectors++;
            if (bus.dropped !== ed) begin miscompares++; $display("FAIL b2b_dropped edge %0d got %b expected %b", e, bus.dropped, ed); end
            vectors++;
            if (bus.drop_cnt !== 8'(exp_cnt)) begin miscompares++; $display("FAIL b2b_drop_cnt edge %0d got %0d expected %0d", e, bus.drop_cnt, exp_cnt); end
        end
        vectors++;
        if (bus.drop_cnt !== 8'd255) begin miscompares++; $display("FAIL b2b_saturated got %0d expected 255", bus.drop_cnt); end
        bus.pulse_in = 1'b0;
    endtask

    initial begin
        bus.pulse_in = 1'b0;
        rst          = 1'b0;
        test_reset();
        test_single();
        test_queued();
        test_drop();
        test_last_gap();
        test_rst_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
